// File: rtl/usc_rv_dispatch_ctl.sv
// Dispatch controller: moves decoded ops from two decode lanes into the dual-port IQ,
// tracks free IQ entries with a credit counter and sequences serializing ops.
//
// state  | meaning
// RUN    | normal in-order dispatch of up to two ops per cycle
// DRAIN  | serial op is oldest; wait for idle backend and empty IQ
// SERIAL | issue the serial op alone on port0
// WAIT   | serial op in flight; hold decode until backend is idle again
module usc_rv_dispatch_ctl #(
  parameter int IQ_DEPTH = 8,
  parameter int CTL_W    = 64,
  parameter int CNT_W    = $clog2(IQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             core_flush,
  input  logic             op0_dec_v_i,
  input  logic [CTL_W-1:0] op0_dec_ctl_i,
  input  logic             op0_serial_i,
  input  logic             op1_dec_v_i,
  input  logic [CTL_W-1:0] op1_dec_ctl_i,
  input  logic             op1_serial_i,
  output logic [1:0]       stall_de_o,
  input  logic [1:0]       iq_release_i,
  input  logic             pipe_empty_i,
  output logic [1:0]       iq_wr_v_o,
  output logic [CTL_W-1:0] iq_wr_ctl0_o,
  output logic [CTL_W-1:0] iq_wr_ctl1_o,
  output logic [CNT_W-1:0] iq_credits_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] credits;
  logic [CNT_W:0]   rel_cnt;
  logic [CNT_W:0]   avail;
  logic [CNT_W:0]   disp_cnt;
  logic [CNT_W:0]   credits_sum;
  logic             oldest_v;
  logic             oldest_serial;
  logic             disp0;
  logic             disp1;

  // Entries freed this cycle are usable by this cycle's dispatch decision.
  assign rel_cnt       = (CNT_W+1)'(iq_release_i[0]) + (CNT_W+1)'(iq_release_i[1]);
  assign avail         = {1'b0, credits} + rel_cnt;
  assign disp_cnt      = (CNT_W+1)'(disp0) + (CNT_W+1)'(disp1);
  assign credits_sum   = avail - disp_cnt;
  assign oldest_v      = op0_dec_v_i | op1_dec_v_i;
  assign oldest_serial = op0_dec_v_i ? op0_serial_i : op1_serial_i;
  assign iq_credits_o  = credits;

  always_comb begin
    state_nxt  = state;
    disp0      = 1'b0;
    disp1      = 1'b0;
    stall_de_o = 2'b11;
    if (core_flush) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (!oldest_v) begin
            stall_de_o = 2'b00;
          end else if (oldest_serial) begin
            state_nxt = ST_DRAIN;
          end else begin
            if (op0_dec_v_i) begin
              disp0 = (avail >= (CNT_W+1)'(1));
              disp1 = disp0 & op1_dec_v_i & ~op1_serial_i & (avail >= (CNT_W+1)'(2));
            end else begin
              disp1 = (avail >= (CNT_W+1)'(1));
            end
            stall_de_o = {op1_dec_v_i & ~disp1, op0_dec_v_i & ~disp0};
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_i && (credits == CNT_W'(IQ_DEPTH))) state_nxt = ST_SERIAL;
        end
        ST_SERIAL: begin
          if (oldest_v) begin
            disp0      = op0_dec_v_i;
            disp1      = ~op0_dec_v_i;
            stall_de_o = {~disp1, ~disp0};
            state_nxt  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pipe_empty_i) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      credits      <= CNT_W'(IQ_DEPTH);
      iq_wr_v_o    <= 2'b00;
      iq_wr_ctl0_o <= '0;
      iq_wr_ctl1_o <= '0;
    end else begin
      state <= state_nxt;
      if (core_flush) begin
        credits   <= CNT_W'(IQ_DEPTH);
        iq_wr_v_o <= 2'b00;
      end else begin
        credits   <= credits_sum[CNT_W-1:0];
        iq_wr_v_o <= {disp0 & disp1, disp0 | disp1};
        if (disp0 | disp1) iq_wr_ctl0_o <= disp0 ? op0_dec_ctl_i : op1_dec_ctl_i;
        if (disp0 & disp1) iq_wr_ctl1_o <= op1_dec_ctl_i;
      end
    end
  end

  // Credit accounting must never wrap in either direction.
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n || core_flush)
    avail >= disp_cnt);
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n || core_flush)
    (avail < disp_cnt) || (credits_sum <= (CNT_W+1)'(IQ_DEPTH)));

endmodule

// File: tb/tb_usc_rv_dispatch_ctl.sv
// Directed bench for usc_rv_dispatch_ctl with a cycle-level reference model
// and hand-computed literal checkpoints.
module tb_usc_rv_dispatch_ctl;
  localparam int IQ_DEPTH = 8;
  localparam int CTL_W    = 64;
  localparam int CNT_W    = $clog2(IQ_DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             core_flush;
  logic             op0_dec_v_i, op0_serial_i, op1_dec_v_i, op1_serial_i;
  logic [CTL_W-1:0] op0_dec_ctl_i, op1_dec_ctl_i;
  logic [1:0]       stall_de_o, iq_release_i, iq_wr_v_o;
  logic             pipe_empty_i;
  logic [CTL_W-1:0] iq_wr_ctl0_o, iq_wr_ctl1_o;
  logic [CNT_W-1:0] iq_credits_o;

  int total = 0;
  int bad   = 0;

  usc_rv_dispatch_ctl #(.IQ_DEPTH(IQ_DEPTH), .CTL_W(CTL_W)) dut (
    .clk(clk), .reset_n(reset_n), .core_flush(core_flush),
    .op0_dec_v_i(op0_dec_v_i), .op0_dec_ctl_i(op0_dec_ctl_i), .op0_serial_i(op0_serial_i),
    .op1_dec_v_i(op1_dec_v_i), .op1_dec_ctl_i(op1_dec_ctl_i), .op1_serial_i(op1_serial_i),
    .stall_de_o(stall_de_o), .iq_release_i(iq_release_i), .pipe_empty_i(pipe_empty_i),
    .iq_wr_v_o(iq_wr_v_o), .iq_wr_ctl0_o(iq_wr_ctl0_o), .iq_wr_ctl1_o(iq_wr_ctl1_o),
    .iq_credits_o(iq_credits_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: free-entry count, serialization phase
  // (0 normal, 1 waiting to start serial op, 2 issuing it, 3 waiting for it to finish)
  // and the values the registered outputs must show next cycle.
  int               m_credits = IQ_DEPTH;
  int               m_phase   = 0;
  logic [1:0]       m_wrv     = 2'b00;
  logic [CTL_W-1:0] m_ctl0    = '0;
  logic [CTL_W-1:0] m_ctl1    = '0;

  always @(negedge clk) begin
    int         oldest;
    int         avail;
    int         n;
    logic       d0, d1, ser;
    logic [1:0] e_stall;
    if (!reset_n) begin
      m_credits = IQ_DEPTH; m_phase = 0; m_wrv = 2'b00; m_ctl0 = '0; m_ctl1 = '0;
      check("rst_wr_v", iq_wr_v_o, 2'b00);
      check("rst_credits", iq_credits_o, IQ_DEPTH);
      check("rst_ctl0", iq_wr_ctl0_o, 0);
      check("rst_ctl1", iq_wr_ctl1_o, 0);
    end else begin
      check("m_wr_v", iq_wr_v_o, m_wrv);
      check("m_credits", iq_credits_o, m_credits);
      check("m_ctl0", iq_wr_ctl0_o, m_ctl0);
      check("m_ctl1", iq_wr_ctl1_o, m_ctl1);
      oldest  = op0_dec_v_i ? 0 : (op1_dec_v_i ? 1 : -1);
      ser     = (oldest == 0) ? op0_serial_i : op1_serial_i;
      avail   = m_credits + int'(iq_release_i[0]) + int'(iq_release_i[1]);
      d0      = 1'b0;
      d1      = 1'b0;
      e_stall = 2'b11;
      if (core_flush) begin
        m_phase = 0; m_credits = IQ_DEPTH; m_wrv = 2'b00;
      end else begin
        if (m_phase == 0) begin
          if (oldest < 0) e_stall = 2'b00;
          else if (ser) m_phase = 1;
          else begin
            if (avail >= 1) begin
              if (oldest == 0) d0 = 1'b1; else d1 = 1'b1;
            end
            if (oldest == 0 && op1_dec_v_i && !op1_serial_i && avail >= 2) d1 = 1'b1;
            e_stall = {op1_dec_v_i & ~d1, op0_dec_v_i & ~d0};
          end
        end else if (m_phase == 1) begin
          if (pipe_empty_i && m_credits == IQ_DEPTH) m_phase = 2;
        end else if (m_phase == 2) begin
          if (oldest >= 0) begin
            if (oldest == 0) d0 = 1'b1; else d1 = 1'b1;
            e_stall = {~d1, ~d0};
            m_phase = 3;
          end
        end else begin
          if (pipe_empty_i) m_phase = 0;
        end
        n = int'(d0) + int'(d1);
        m_credits = avail - n;
        m_wrv = (n == 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
        if (n >= 1) m_ctl0 = (oldest == 0) ? op0_dec_ctl_i : op1_dec_ctl_i;
        if (n == 2) m_ctl1 = op1_dec_ctl_i;
      end
      check("m_stall", stall_de_o, e_stall);
    end
  end

  task automatic set_in(input logic v0, input logic s0, input logic [63:0] c0,
                        input logic v1, input logic s1, input logic [63:0] c1,
                        input logic [1:0] rel, input logic pe, input logic fl);
    op0_dec_v_i = v0; op0_serial_i = s0; op0_dec_ctl_i = c0;
    op1_dec_v_i = v1; op1_serial_i = s1; op1_dec_ctl_i = c1;
    iq_release_i = rel; pipe_empty_i = pe; core_flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("lit_rst_credits", iq_credits_o, 8);
    check("lit_rst_stall", stall_de_o, 2'b00);

    // Both lanes, full credits
    set_in(1, 0, 64'hA0, 1, 0, 64'hB0, 2'b00, 1, 0);
    #1 check("lit_both_stall", stall_de_o, 2'b00);
    step();
    check("lit_both_wr_v", iq_wr_v_o, 2'b11);
    check("lit_both_ctl0", iq_wr_ctl0_o, 64'hA0);
    check("lit_both_ctl1", iq_wr_ctl1_o, 64'hB0);
    check("lit_both_credits", iq_credits_o, 6);
    set_in(1, 0, 64'hA1, 1, 0, 64'hB1, 2'b00, 1, 0); step();
    set_in(1, 0, 64'hA2, 1, 0, 64'hB2, 2'b00, 1, 0); step();
    set_in(1, 0, 64'hA3, 0, 0, 64'h0,  2'b00, 1, 0); step();
    check("lit_credits_one", iq_credits_o, 1);

    // One credit: only lane0 goes
    set_in(1, 0, 64'hA4, 1, 0, 64'hB4, 2'b00, 1, 0);
    #1 check("lit_c1_stall", stall_de_o, 2'b10);
    step();
    check("lit_c1_wr_v", iq_wr_v_o, 2'b01);
    check("lit_c1_credits", iq_credits_o, 0);

    // Zero credits but two released this cycle
    set_in(1, 0, 64'hA5, 1, 0, 64'hB5, 2'b11, 1, 0);
    #1 check("lit_rel_stall", stall_de_o, 2'b00);
    step();
    check("lit_rel_wr_v", iq_wr_v_o, 2'b11);
    check("lit_rel_credits", iq_credits_o, 0);

    set_in(0, 0, 0, 0, 0, 0, 2'b11, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 1, 0); step();
    check("lit_credits_three", iq_credits_o, 3);

    // Lane1 alone uses port0
    set_in(0, 0, 0, 1, 0, 64'hC0, 2'b00, 1, 0);
    #1 check("lit_l1_stall", stall_de_o, 2'b00);
    step();
    check("lit_l1_wr_v", iq_wr_v_o, 2'b01);
    check("lit_l1_ctl0", iq_wr_ctl0_o, 64'hC0);
    check("lit_l1_credits", iq_credits_o, 2);

    // ADD + CSR: ADD alone, then drain, serial, wait
    set_in(1, 0, 64'hD0, 1, 1, 64'hE0, 2'b00, 0, 0);
    #1 check("lit_add_csr_stall", stall_de_o, 2'b10);
    step();
    check("lit_add_ctl0", iq_wr_ctl0_o, 64'hD0);
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b00, 0, 0);
    #1 check("lit_csr_old_stall", stall_de_o, 2'b11);
    step();
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b11, 0, 0); step();
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b11, 0, 0); step();
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b11, 0, 0); step();
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b01, 0, 0);
    #1 check("lit_drain_stall", stall_de_o, 2'b11);
    step();
    check("lit_drain_credits", iq_credits_o, 8);
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b00, 1, 0); step();
    set_in(0, 0, 0, 1, 1, 64'hE0, 2'b00, 0, 0);
    #1 check("lit_serial_stall", stall_de_o, 2'b01);
    step();
    check("lit_serial_wr_v", iq_wr_v_o, 2'b01);
    check("lit_serial_ctl0", iq_wr_ctl0_o, 64'hE0);
    check("lit_serial_credits", iq_credits_o, 7);
    set_in(1, 0, 64'hF0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("lit_wait_stall", stall_de_o, 2'b11);
    step();
    step();
    set_in(1, 0, 64'hF0, 0, 0, 0, 2'b00, 1, 0); step();
    check("lit_wait_wr_v", iq_wr_v_o, 2'b00);
    set_in(1, 0, 64'hF0, 0, 0, 0, 2'b00, 1, 0);
    #1 check("lit_after_serial_stall", stall_de_o, 2'b00);
    step();
    check("lit_after_serial_ctl0", iq_wr_ctl0_o, 64'hF0);

    // Flush while draining with five credits
    set_in(1, 0, 64'h10, 0, 0, 0, 2'b00, 0, 0); step();
    set_in(1, 1, 64'h11, 0, 0, 0, 2'b00, 0, 0); step();
    check("lit_pre_flush_credits", iq_credits_o, 5);
    set_in(1, 1, 64'h11, 0, 0, 0, 2'b01, 1, 1);
    #1 check("lit_flush_stall", stall_de_o, 2'b11);
    step();
    check("lit_flush_wr_v", iq_wr_v_o, 2'b00);
    check("lit_flush_credits", iq_credits_o, 8);
    set_in(1, 0, 64'h12, 0, 0, 0, 2'b00, 0, 0);
    #1 check("lit_post_flush_stall", stall_de_o, 2'b00);
    step();
    check("lit_post_flush_wr_v", iq_wr_v_o, 2'b01);
    check("lit_post_flush_ctl0", iq_wr_ctl0_o, 64'h12);

    // Reset asserted during WAIT
    set_in(0, 0, 0, 0, 0, 0, 2'b01, 1, 0); step();
    set_in(1, 1, 64'h20, 1, 0, 64'h21, 2'b00, 1, 0); step();
    step();
    set_in(1, 1, 64'h20, 1, 0, 64'h21, 2'b00, 1, 0);
    #1 check("lit_serial2_stall", stall_de_o, 2'b10);
    step();
    check("lit_serial2_wr_v", iq_wr_v_o, 2'b01);
    set_in(1, 0, 64'h22, 1, 0, 64'h23, 2'b00, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check("lit_async_rst_wr_v", iq_wr_v_o, 2'b00);
    check("lit_async_rst_credits", iq_credits_o, 8);
    step();
    reset_n = 1'b1;
    #1 check("lit_post_rst_stall", stall_de_o, 2'b00);
    step();
    check("lit_post_rst_wr_v", iq_wr_v_o, 2'b11);
    check("lit_post_rst_ctl0", iq_wr_ctl0_o, 64'h22);
    check("lit_post_rst_ctl1", iq_wr_ctl1_o, 64'h23);
    check("lit_post_rst_credits", iq_credits_o, 6);

    set_in(0, 0, 0, 0, 0, 0, 2'b11, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 0); step();
    step();
    check("lit_end_credits", iq_credits_o, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
